// File: rtl/alu_op_sequencer_if.sv
// Bus bundle between the operation sequencer, the byte-wide system memory and the ALU.
// master is the sequencer side; slave is the memory/ALU/host side.
interface alu_op_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [7:0]        num_ops;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [7:0]        mem_rdata;
    logic              mem_wr_en;
    logic [7:0]        mem_wdata;
    logic [7:0]        alu_a;
    logic [7:0]        alu_b;
    logic [7:0]        alu_oper;
    logic [7:0]        alu_execute;
    logic [15:0]       alu_res;

    modport master (
        input  start, num_ops, src_base, dst_base, mem_rdata, alu_res,
        output busy, done, err, mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
               alu_a, alu_b, alu_oper, alu_execute
    );

    modport slave (
        output start, num_ops, src_base, dst_base, mem_rdata, alu_res,
        input  busy, done, err, mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
               alu_a, alu_b, alu_oper, alu_execute
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Fetches (OPER, A, B) records from memory, runs each through the ALU for one cycle
// and writes the 16-bit result back as two bytes, low byte first.
module alu_op_sequencer #(
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    alu_op_sequencer_if.master  bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH_OP,
        S_FETCH_A,
        S_FETCH_B,
        S_LOAD_B,
        S_EXEC,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [7:0]        num_reg;
    logic [ADDR_W-1:0] src_reg;
    logic [ADDR_W-1:0] dst_reg;
    logic [7:0]        idx_reg;
    logic [15:0]       result_reg;
    logic              err_reg;
    logic [7:0]        alu_a_reg;
    logic [7:0]        alu_b_reg;
    logic [7:0]        alu_oper_reg;

    logic [ADDR_W-1:0] rd_base;
    logic [ADDR_W-1:0] wr_base;
    logic              last_rec;
    logic              illegal_op;

    // Record and result base addresses wrap naturally at ADDR_W bits.
    assign rd_base    = src_reg + ADDR_W'({2'b00, idx_reg} * 10'd3);
    assign wr_base    = dst_reg + ADDR_W'({idx_reg, 1'b0});
    assign last_rec   = (idx_reg == (num_reg - 8'd1));
    assign illegal_op = (alu_oper_reg[2:0] >= 3'd5);

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = (bus.num_ops != 8'd0) ? S_FETCH_OP : S_DONE;
                end
            end
            S_FETCH_OP: state_next = S_FETCH_A;
            S_FETCH_A:  state_next = S_FETCH_B;
            S_FETCH_B:  state_next = S_LOAD_B;
            S_LOAD_B:   state_next = S_EXEC;
            S_EXEC:     state_next = S_WR_LO;
            S_WR_LO:    state_next = S_WR_HI;
            S_WR_HI:    state_next = last_rec ? S_DONE : S_FETCH_OP;
            S_DONE:     state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            num_reg      <= '0;
            src_reg      <= '0;
            dst_reg      <= '0;
            idx_reg      <= '0;
            result_reg   <= '0;
            err_reg      <= 1'b0;
            alu_a_reg    <= '0;
            alu_b_reg    <= '0;
            alu_oper_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        err_reg <= 1'b0;
                        if (bus.num_ops != 8'd0) begin
                            num_reg <= bus.num_ops;
                            src_reg <= bus.src_base;
                            dst_reg <= bus.dst_base;
                            idx_reg <= '0;
                        end
                    end
                end
                S_FETCH_A: alu_oper_reg <= bus.mem_rdata;
                S_FETCH_B: alu_a_reg    <= bus.mem_rdata;
                S_LOAD_B:  alu_b_reg    <= bus.mem_rdata;
                S_EXEC: begin
                    // Divide-by-zero keeps the ALU's own marker result; illegal opcodes store zero.
                    if (illegal_op) begin
                        result_reg <= 16'h0000;
                        err_reg    <= 1'b1;
                    end else begin
                        result_reg <= bus.alu_res;
                        if (alu_oper_reg[2:0] == 3'd4 && alu_b_reg == 8'd0) begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                S_WR_HI: begin
                    if (!last_rec) begin
                        idx_reg <= idx_reg + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory and ALU strobes come purely from state and registers.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_rd_en = 1'b0;
        bus.mem_wr_en = 1'b0;
        bus.mem_wdata = 8'h00;
        unique case (state_reg)
            S_FETCH_OP: begin
                bus.mem_addr  = rd_base;
                bus.mem_rd_en = 1'b1;
            end
            S_FETCH_A: begin
                bus.mem_addr  = rd_base + ADDR_W'(1);
                bus.mem_rd_en = 1'b1;
            end
            S_FETCH_B: begin
                bus.mem_addr  = rd_base + ADDR_W'(2);
                bus.mem_rd_en = 1'b1;
            end
            S_WR_LO: begin
                bus.mem_addr  = wr_base;
                bus.mem_wr_en = 1'b1;
                bus.mem_wdata = result_reg[7:0];
            end
            S_WR_HI: begin
                bus.mem_addr  = wr_base + ADDR_W'(1);
                bus.mem_wr_en = 1'b1;
                bus.mem_wdata = result_reg[15:8];
            end
            default: ;
        endcase
    end

    assign bus.busy        = (state_reg != S_IDLE);
    assign bus.done        = (state_reg == S_DONE);
    assign bus.err         = err_reg;
    assign bus.alu_a       = alu_a_reg;
    assign bus.alu_b       = alu_b_reg;
    assign bus.alu_oper    = alu_oper_reg;
    assign bus.alu_execute = (state_reg == S_EXEC) ? 8'h01 : 8'h00;

endmodule
